// File: rtl/sram_mem_ctrl_pkg.sv
// Shared SRAM geometry, default data-memory base and controller state encoding.
// Also hosts the CPU-address to SRAM-word-index mapping used by the controller.
package sram_mem_ctrl_pkg;

   localparam int SRAM_ADDR_LEN = 18;
   localparam int SRAM_DATA_LEN = 16;
   localparam int IDX_LEN       = SRAM_ADDR_LEN - 1;

   localparam logic [31:0] DATA_MEM_BASE_DEF = 32'd1024;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      LO   = ST_LO,
      HI   = ST_HI,
      DONE = ST_DONE
   } state_t;

   // Addresses below the base wrap modulo 2^32 and then modulo the SRAM word count.
   function automatic logic [IDX_LEN-1:0] word_idx(input logic [31:0] address,
                                                   input logic [31:0] base);
      return IDX_LEN'((address - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits one 32-bit MEM-stage load/store into two 16-bit async-SRAM accesses.
// Latency: ready low for 1 + 2*ACCESS_CYCLES cycles; with SRAM_POSTED_WRITE_EN writes return ready at once.
// Backpressure: ready=0 freezes the pipeline; rd_en/wr_en are only sampled in IDLE.
module sram_mem_ctrl
   import sram_mem_ctrl_pkg::*;
#(
   parameter int          ACCESS_CYCLES = 2,
   parameter logic [31:0] DATA_MEM_BASE = DATA_MEM_BASE_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic                     wr_en,
   input  logic [31:0]              address,
   input  logic [31:0]              write_data,
   output logic [31:0]              read_data,
   output logic                     ready,
   output logic [SRAM_ADDR_LEN-1:0] sram_addr,
   output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
   input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
   output logic                     sram_dq_oe,
   output logic                     sram_we_n
);

`ifdef SRAM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   localparam int              CNT_W    = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_wr_q;
   logic [IDX_LEN-1:0]   idx_q;
   logic [31:0]          wdata_q;

   logic                 req;
   logic                 start;
   logic                 cnt_last;
   logic                 wr_nxt;
   logic [IDX_LEN-1:0]   idx_nxt;
   logic [31:0]          wdata_nxt;

   assign req      = rd_en | wr_en;
   assign start    = (state_q == IDLE) && req;
   assign cnt_last = (cnt_q == CNT_LAST);

   // Values the SRAM pins must show next cycle: fresh request on entry, latched copy afterwards.
   assign wr_nxt    = start ? wr_en : is_wr_q;
   assign idx_nxt   = start ? word_idx(address, DATA_MEM_BASE) : idx_q;
   assign wdata_nxt = start ? write_data : wdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready   = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = ~req | (POSTED & wr_en);
            if (req) begin
               state_d = LO;
               cnt_d   = '0;
            end
         end
         LO: begin
            ready = POSTED & is_wr_q & ~req;
            if (cnt_last) begin
               state_d = HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HI: begin
            ready = POSTED & is_wr_q & ~req;
            if (cnt_last) begin
               // A posted write has already released the pipeline, so there is no DONE handshake.
               state_d = (POSTED && is_wr_q) ? IDLE : DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;

         if (start) begin
            is_wr_q <= wr_en;
            idx_q   <= word_idx(address, DATA_MEM_BASE);
            wdata_q <= write_data;
         end

         // Read data is sampled on the last cycle each half-address is held.
         if (!is_wr_q && cnt_last) begin
            if (state_q == LO) begin
               read_data[15:0] <= sram_dq_in;
            end else if (state_q == HI) begin
               read_data[31:16] <= sram_dq_in;
            end
         end

         unique case (state_d)
            LO: begin
               sram_addr   <= {idx_nxt, 1'b0};
               sram_dq_out <= wdata_nxt[15:0];
               sram_we_n   <= ~wr_nxt;
               sram_dq_oe  <= wr_nxt;
            end
            HI: begin
               sram_addr   <= {idx_q, 1'b1};
               sram_dq_out <= wdata_q[31:16];
               sram_we_n   <= ~is_wr_q;
               sram_dq_oe  <= is_wr_q;
            end
            default: begin
               sram_we_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomised bench for sram_mem_ctrl against a word-level memory model and a behavioural async SRAM.
// Honours SRAM_POSTED_WRITE_EN for the expected stall profile.
module tb_sram_mem_ctrl;

   localparam int AC = 2;
`ifdef SRAM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   sram_mem_ctrl #(.ACCESS_CYCLES(AC), .DATA_MEM_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit pend     = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pat(input int a);
      return 16'(a) ^ 16'h5A3C;
   endfunction

   // Asynchronous SRAM: combinational read, written at each clock edge while we_n is low.
   logic [15:0] sram [0:262143];
   assign sram_dq_in = sram[sram_addr];

   initial begin
      for (int i = 0; i < 262144; i++) sram[i] = pat(i);
      forever begin
         @(posedge clk);
         if (!sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_out;
      end
   end

   // Reference: 32-bit words by index, initial contents follow the SRAM fill pattern.
   logic [31:0] ref_words [int];

   function automatic int model_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'd1024;
      return int'((off / 32'd4) % 32'd131072);
   endfunction

   function automatic logic [31:0] ref_read(input int idx);
      if (ref_words.exists(idx)) return ref_words[idx];
      return {pat(2 * idx + 1), pat(2 * idx)};
   endfunction

   task automatic do_access(input bit wr, input bit both, input logic [31:0] addr,
                            input logic [31:0] data, input string tag);
      int          stall, off, exp_stall, idx, k;
      logic [17:0] s_addr [32];
      logic [15:0] s_dq   [32];
      logic        s_we   [32];
      logic        s_oe   [32];
      idx       = model_idx(addr);
      off       = pend ? 2 * AC : 0;
      exp_stall = off + ((wr && POSTED) ? 0 : 1 + 2 * AC);
      @(negedge clk);
      wr_en      = wr;
      rd_en      = !wr || both;
      address    = addr;
      write_data = data;
      #1;
      stall = 0;
      while (!ready && stall < 30) begin
         @(posedge clk);
         #1;
         s_addr[stall] = sram_addr;
         s_dq[stall]   = sram_dq_out;
         s_we[stall]   = sram_we_n;
         s_oe[stall]   = sram_dq_oe;
         stall++;
      end
      check({tag, " stall"}, stall, exp_stall);
      if (stall >= off + 2 * AC) begin
         for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < AC; c++) begin
               k = off + h * AC + c;
               check({tag, " addr"}, 32'(s_addr[k]), 32'(2 * idx + h));
               check({tag, " we_n"}, 32'(s_we[k]), 32'(!wr));
               check({tag, " oe"}, 32'(s_oe[k]), 32'(wr));
               if (wr) check({tag, " dq"}, 32'(s_dq[k]), (h == 1) ? 32'(data[31:16]) : 32'(data[15:0]));
            end
         end
      end
      if (stall > off + 2 * AC) begin
         check({tag, " done we_n"}, 32'(s_we[off + 2 * AC]), 32'd1);
         check({tag, " done oe"}, 32'(s_oe[off + 2 * AC]), 32'd0);
      end
      if (!wr) begin
         check({tag, " rdata"}, read_data, ref_read(idx));
      end else begin
         ref_words[idx] = data;
         if (!POSTED) begin
            check({tag, " sram lo"}, 32'(sram[2 * idx]), 32'(data[15:0]));
            check({tag, " sram hi"}, 32'(sram[2 * idx + 1]), 32'(data[31:16]));
         end
      end
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wr_en = 1'b0;
      pend  = POSTED && wr;
   endtask

   initial begin
      bit          wr, both;
      logic [31:0] a;
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", 32'(ready), 32'd1);
      check("reset we_n", 32'(sram_we_n), 32'd1);
      check("reset oe", 32'(sram_dq_oe), 32'd0);
      check("reset rdata", read_data, 32'd0);
      check("reset addr", 32'(sram_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr1024");
      do_access(1'b0, 1'b0, 32'd1024, 32'h0, "rd1024");
      do_access(1'b1, 1'b0, 32'd1036, 32'h12345678, "wr1036");
      do_access(1'b0, 1'b0, 32'd1036, 32'h0, "rd1036");
      check("sram[6]", 32'(sram[6]), 32'h5678);
      check("sram[7]", 32'(sram[7]), 32'h1234);

      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom_range(0, 1));
         both = wr && ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'd4 * $urandom_range(1, 3);
         else                           a = 32'd1024 + 32'd4 * $urandom_range(0, 15);
         do_access(wr, both, a, $urandom, "rnd");
      end

      // Abort a write in its high half with a synchronous reset.
      repeat (2 * AC + 2) @(posedge clk);
      pend = 1'b0;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1024 + 32'd400; write_data = 32'hCAFEF00D;
      repeat (AC + 1) @(posedge clk);
      #1;
      check("abort in hi addr", 32'(sram_addr), 32'(2 * 100 + 1));
      check("abort in hi we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b1; wr_en = 1'b0;
      @(posedge clk);
      #1;
      check("abort ready", 32'(ready), 32'd1);
      check("abort we_n", 32'(sram_we_n), 32'd1);
      check("abort oe", 32'(sram_dq_oe), 32'd0);
      rst = 1'b0;
      do_access(1'b0, 1'b0, 32'd1024 + 32'd200, 32'h0, "rd untouched");
      do_access(1'b0, 1'b0, 32'd1024, 32'h0, "rd1024 again");

      repeat (2 * AC + 4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
      $fatal(1);
   end

endmodule
